// File: rtl/riscv_pkg.sv
// ============================================================================
//  Module   : riscv_pkg
//  Brief    : ALU opcodes, Mem-control bit positions and EX-stage FSM states.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_MUL = 4'b1111;

   localparam int MEM_RD = 1;
   localparam int MEM_WR = 0;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ex_mem_stage_if.sv
// ============================================================================
//  Module   : ex_mem_stage_if
//  Brief    : ID/EX, MEM/WB and EX/MEM signal bundle of the execute stage.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ex_mem_stage_if #(
   parameter int XLEN = 32
);
   logic            valid_i;
   logic [XLEN-1:0] val1_i;
   logic [XLEN-1:0] val2_i;
   logic            alu_src_i;
   logic [3:0]      alu_ctrl_i;
   logic [4:0]      rs1_addr_i;
   logic [4:0]      rs2_addr_i;
   logic [4:0]      rd_addr_i;
   logic [XLEN-1:0] simm_i;
   logic [1:0]      mem_i;
   logic            wb_i;
   logic            memwb_wb_i;
   logic [4:0]      memwb_rd_i;
   logic [XLEN-1:0] memwb_data_i;
   logic            stall_o;
   logic            valid_o;
   logic [XLEN-1:0] alu_result_o;
   logic [XLEN-1:0] store_data_o;
   logic [4:0]      rd_addr_o;
   logic [1:0]      mem_o;
   logic            wb_o;

   modport master (
      output valid_i, val1_i, val2_i, alu_src_i, alu_ctrl_i, rs1_addr_i, rs2_addr_i,
             rd_addr_i, simm_i, mem_i, wb_i, memwb_wb_i, memwb_rd_i, memwb_data_i,
      input  stall_o, valid_o, alu_result_o, store_data_o, rd_addr_o, mem_o, wb_o
   );

   modport slave (
      input  valid_i, val1_i, val2_i, alu_src_i, alu_ctrl_i, rs1_addr_i, rs2_addr_i,
             rd_addr_i, simm_i, mem_i, wb_i, memwb_wb_i, memwb_rd_i, memwb_data_i,
      output stall_o, valid_o, alu_result_o, store_data_o, rd_addr_o, mem_o, wb_o
   );

endinterface

`default_nettype wire

// File: rtl/ex_mem_stage_mul_iter.sv
// ============================================================================
//  Module   : mul_iter
//  Brief    : Iterative shift-add multiplier, XLEN/MUL_CYCLES multiplier bits
//             per clock; product_o is final while done_o is high.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_iter #(
   parameter int XLEN       = 32,
   parameter int MUL_CYCLES = 4
) (
   input  wire logic            clk_i,
   input  wire logic            rst_i,
   input  wire logic            start_i,
   input  wire logic [XLEN-1:0] a_i,
   input  wire logic [XLEN-1:0] b_i,
   output logic      [XLEN-1:0] product_o,
   output logic                 done_o
);

   localparam int c_step = XLEN / MUL_CYCLES;

   logic [XLEN-1:0]       r_acc;
   logic [XLEN-1:0]       r_a;
   logic [XLEN-1:0]       r_b;
   logic [MUL_CYCLES-1:0] r_mark;
   logic [XLEN-1:0]       w_first;
   logic [XLEN-1:0]       w_partial;

   // The start edge already folds in the lowest chunk, so the last chunk is
   // added combinationally into product_o rather than on an extra edge.
   assign w_first   = a_i * XLEN'(b_i[c_step-1:0]);
   assign w_partial = r_a * XLEN'(r_b[c_step-1:0]);
   assign product_o = r_acc + w_partial;
   assign done_o    = r_mark[MUL_CYCLES-1];

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_acc  <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_mark <= '0;
      end else if (start_i) begin
         r_acc  <= w_first;
         r_a    <= a_i << c_step;
         r_b    <= b_i >> c_step;
         r_mark <= MUL_CYCLES'(2);
      end else begin
         r_acc  <= r_acc + w_partial;
         r_a    <= r_a << c_step;
         r_b    <= r_b >> c_step;
         r_mark <= r_mark << 1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/ex_mem_stage.sv
// ============================================================================
//  Module   : ex_mem_stage
//  Brief    : Execute stage with forwarding, ALU, iterative multiply and the
//             EX/MEM register. Macro FORWARDING_EN enables operand forwarding.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_stage
   import riscv_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int MUL_CYCLES = 4
) (
   input wire logic     clk_i,
   input wire logic     rst_i,
   ex_mem_stage_if.slave bus
);

   localparam int c_cnt_w = $clog2(MUL_CYCLES);

   logic [0:0]         r_state;
   logic [0:0]         w_state_nxt;
   logic [c_cnt_w-1:0] r_cnt;
   logic               w_is_mul;
   logic               w_start;
   logic               w_finish;
   logic               w_stall;
   logic               w_mul_done;
   logic [XLEN-1:0]    w_product;
   logic [XLEN-1:0]    w_op1;
   logic [XLEN-1:0]    w_op2;
   logic [XLEN-1:0]    w_alu;

   logic               r_valid;
   logic [XLEN-1:0]    r_result;
   logic [XLEN-1:0]    r_store;
   logic [4:0]         r_rd;
   logic [1:0]         r_mem;
   logic               r_wb;
   logic [4:0]         r_mul_rd;
   logic [1:0]         r_mul_mem;
   logic               r_mul_wb;

   assign w_is_mul = bus.valid_i && (bus.alu_ctrl_i == ALU_MUL);

`ifdef FORWARDING_EN
   logic w_exmem_ok;
   logic w_memwb_ok;

   // A load's EX/MEM value is an address, not the loaded data, so it is skipped.
   assign w_exmem_ok = r_wb && !r_mem[MEM_RD] && (r_rd != 5'd0);
   assign w_memwb_ok = bus.memwb_wb_i && (bus.memwb_rd_i != 5'd0);

   always_comb begin
      w_op1 = bus.val1_i;
      if (w_exmem_ok && (r_rd == bus.rs1_addr_i))
         w_op1 = r_result;
      else if (w_memwb_ok && (bus.memwb_rd_i == bus.rs1_addr_i))
         w_op1 = bus.memwb_data_i;

      w_op2 = bus.val2_i;
      if (!bus.alu_src_i) begin
         if (w_exmem_ok && (r_rd == bus.rs2_addr_i))
            w_op2 = r_result;
         else if (w_memwb_ok && (bus.memwb_rd_i == bus.rs2_addr_i))
            w_op2 = bus.memwb_data_i;
      end
   end
`else
   logic w_unused_nofwd;

   assign w_op1          = bus.val1_i;
   assign w_op2          = bus.val2_i;
   assign w_unused_nofwd = ^{bus.rs1_addr_i, bus.rs2_addr_i, bus.alu_src_i,
                             bus.memwb_wb_i, bus.memwb_rd_i, bus.memwb_data_i};
`endif

   always_comb begin
      unique case (bus.alu_ctrl_i)
         ALU_SUB: w_alu = w_op1 - w_op2;
         ALU_AND: w_alu = w_op1 & w_op2;
         ALU_OR:  w_alu = w_op1 | w_op2;
         default: w_alu = w_op1 + w_op2;
      endcase
      if (bus.mem_i[MEM_WR])
         w_alu = w_op1 + bus.simm_i;
   end

   mul_iter #(
      .XLEN       (XLEN),
      .MUL_CYCLES (MUL_CYCLES)
   ) u_mul_iter (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .start_i   (w_start),
      .a_i       (w_op1),
      .b_i       (w_op2),
      .product_o (w_product),
      .done_o    (w_mul_done)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_i)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: if (w_is_mul) w_state_nxt = ST_BUSY;
         ST_BUSY: if (w_finish) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_start  = 1'b0;
      w_stall  = 1'b0;
      w_finish = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_start = w_is_mul;
            w_stall = w_is_mul;
         end
         ST_BUSY: begin
            w_stall  = 1'b1;
            w_finish = (r_cnt == c_cnt_w'(MUL_CYCLES - 1)) && w_mul_done;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_cnt     <= '0;
         r_mul_rd  <= '0;
         r_mul_mem <= '0;
         r_mul_wb  <= 1'b0;
      end else if (w_start) begin
         r_cnt     <= c_cnt_w'(1);
         r_mul_rd  <= bus.rd_addr_i;
         r_mul_mem <= bus.mem_i;
         r_mul_wb  <= bus.wb_i;
      end else if (r_state == ST_BUSY) begin
         r_cnt     <= w_finish ? '0 : r_cnt + c_cnt_w'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i || (r_state == ST_BUSY && !w_finish) || (r_state == ST_IDLE && (w_start || !bus.valid_i))) begin
         r_valid  <= 1'b0;
         r_result <= '0;
         r_store  <= '0;
         r_rd     <= '0;
         r_mem    <= '0;
         r_wb     <= 1'b0;
      end else if (r_state == ST_BUSY) begin
         r_valid  <= 1'b1;
         r_result <= w_product;
         r_store  <= '0;
         r_rd     <= r_mul_rd;
         r_mem    <= r_mul_mem;
         r_wb     <= r_mul_wb;
      end else begin
         r_valid  <= 1'b1;
         r_result <= w_alu;
         r_store  <= w_op2;
         r_rd     <= bus.rd_addr_i;
         r_mem    <= bus.mem_i;
         r_wb     <= bus.wb_i;
      end
   end

   assign bus.stall_o      = rst_i && w_stall;
   assign bus.valid_o      = r_valid;
   assign bus.alu_result_o = r_result;
   assign bus.store_data_o = r_store;
   assign bus.rd_addr_o    = r_rd;
   assign bus.mem_o        = r_mem;
   assign bus.wb_o         = r_wb;

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
// ============================================================================
//  Module   : tb_ex_mem_stage
//  Brief    : Scoreboard bench for ex_mem_stage (XLEN=32, MUL_CYCLES=4).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_mem_stage;
   import riscv_pkg::*;

   localparam int c_xlen       = 32;
   localparam int c_mul_cycles = 4;

   typedef struct packed {
      logic        valid;
      logic        alu_src;
      logic [3:0]  ctrl;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] val1;
      logic [31:0] val2;
      logic [31:0] simm;
      logic [1:0]  mem;
      logic        wb;
      logic        mwb;
      logic [4:0]  mrd;
      logic [31:0] mdata;
   } stim_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] result;
      logic [31:0] store;
      logic        chk_store;
      logic [4:0]  rd;
      logic [1:0]  mem;
      logic        wb;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t m_prev;
   exp_t m_mul;
   int   m_busy;

   always #5 clk = ~clk;

   ex_mem_stage_if #(.XLEN(c_xlen)) bus ();

   ex_mem_stage #(
      .XLEN       (c_xlen),
      .MUL_CYCLES (c_mul_cycles)
   ) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus.slave)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] raw,
                                       input stim_t s, input exp_t prev);
      logic en;
`ifdef FORWARDING_EN
      en = 1'b1;
`else
      en = 1'b0;
`endif
      if (en && prev.wb && !prev.mem[1] && prev.rd != 5'd0 && prev.rd == rs) return prev.result;
      if (en && s.mwb && s.mrd != 5'd0 && s.mrd == rs) return s.mdata;
      return raw;
   endfunction

   function automatic stim_t op(input logic [3:0] ctrl, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [31:0] v1,
                                input logic [4:0] rs2, input logic [31:0] v2);
      stim_t s;
      s       = '0;
      s.valid = 1'b1;
      s.wb    = 1'b1;
      s.ctrl  = ctrl;
      s.rd    = rd;
      s.rs1   = rs1;
      s.val1  = v1;
      s.rs2   = rs2;
      s.val2  = v2;
      return s;
   endfunction

   task automatic drive(input stim_t s);
      bus.valid_i      = s.valid;
      bus.val1_i       = s.val1;
      bus.val2_i       = s.val2;
      bus.alu_src_i    = s.alu_src;
      bus.alu_ctrl_i   = s.ctrl;
      bus.rs1_addr_i   = s.rs1;
      bus.rs2_addr_i   = s.rs2;
      bus.rd_addr_i    = s.rd;
      bus.simm_i       = s.simm;
      bus.mem_i        = s.mem;
      bus.wb_i         = s.wb;
      bus.memwb_wb_i   = s.mwb;
      bus.memwb_rd_i   = s.mrd;
      bus.memwb_data_i = s.mdata;
   endtask

   // One clock: drive at the falling edge, predict, push, then pop after the rising edge.
   task automatic cycle(input stim_t s, input logic rstn);
      exp_t        e;
      exp_t        got;
      logic        exp_stall;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [31:0] res;
      drive(s);
      rst_n     = rstn;
      exp_stall = rstn && (m_busy > 0 || (s.valid && s.ctrl == ALU_MUL));
      #1;
      check("stall_o", {31'b0, bus.stall_o}, {31'b0, exp_stall});
      e           = '0;
      e.chk_store = 1'b1;
      if (!rstn) begin
         m_busy = 0;
      end else if (m_busy > 0) begin
         m_busy--;
         if (m_busy == 0) e = m_mul;
      end else if (s.valid) begin
         op1 = fwd(s.rs1, s.val1, s, m_prev);
         op2 = s.alu_src ? s.val2 : fwd(s.rs2, s.val2, s, m_prev);
         if (s.ctrl == ALU_MUL) begin
            m_mul           = '0;
            m_mul.valid     = 1'b1;
            m_mul.result    = op1 * op2;
            m_mul.chk_store = 1'b0;
            m_mul.rd        = s.rd;
            m_mul.mem       = s.mem;
            m_mul.wb        = s.wb;
            m_busy          = c_mul_cycles - 1;
         end else begin
            case (s.ctrl)
               ALU_SUB: res = op1 - op2;
               ALU_AND: res = op1 & op2;
               ALU_OR:  res = op1 | op2;
               default: res = op1 + op2;
            endcase
            if (s.mem[0]) res = op1 + s.simm;
            e.valid  = 1'b1;
            e.result = res;
            e.store  = op2;
            e.rd     = s.rd;
            e.mem    = s.mem;
            e.wb     = s.wb;
         end
      end
      sb.push_back(e);
      m_prev = e;
      @(posedge clk);
      #1;
      got = sb.pop_front();
      check("valid_o", {31'b0, bus.valid_o}, {31'b0, got.valid});
      check("alu_result_o", bus.alu_result_o, got.result);
      if (got.chk_store) check("store_data_o", bus.store_data_o, got.store);
      check("rd_addr_o", {27'b0, bus.rd_addr_o}, {27'b0, got.rd});
      check("mem_o", {30'b0, bus.mem_o}, {30'b0, got.mem});
      check("wb_o", {31'b0, bus.wb_o}, {31'b0, got.wb});
      @(negedge clk);
   endtask

   initial begin
      stim_t s;
      stim_t bub;
      bub    = '0;
      m_prev = '0;
      m_busy = 0;
      rst_n  = 1'b0;
      drive(bub);
      @(negedge clk);

      s = op(ALU_ADD, 5'd1, 5'd10, 32'd5, 5'd11, 32'd7);
      cycle(s, 1'b0);
      cycle(s, 1'b0);

      cycle(op(ALU_ADD, 5'd1, 5'd10, 32'd5, 5'd11, 32'd7), 1'b1);
      cycle(op(ALU_SUB, 5'd2, 5'd1, 32'd99, 5'd12, 32'd2), 1'b1);

      s = op(ALU_OR, 5'd4, 5'd3, 32'd0, 5'd13, 32'd0);
      s.alu_src = 1'b1; s.val2 = 32'h0F; s.mwb = 1'b1; s.mrd = 5'd3; s.mdata = 32'h100;
      cycle(s, 1'b1);

      cycle(op(ALU_ADD, 5'd0, 5'd5, 32'd50, 5'd6, 32'd0), 1'b1);
      cycle(op(ALU_ADD, 5'd7, 5'd0, 32'd1, 5'd0, 32'd2), 1'b1);

      cycle(op(ALU_ADD, 5'd8, 5'd0, 32'h21, 5'd0, 32'd0), 1'b1);
      s = op(ALU_ADD, 5'd9, 5'd14, 32'd1, 5'd8, 32'd5);
      s.alu_src = 1'b1;
      cycle(s, 1'b1);

      s = op(ALU_ADD, 5'd10, 5'd0, 32'h80, 5'd0, 32'd4);
      s.mem = 2'b10;
      cycle(s, 1'b1);
      cycle(op(ALU_ADD, 5'd11, 5'd10, 32'd1, 5'd0, 32'd1), 1'b1);

      cycle(op(4'b0101, 5'd12, 5'd0, 32'd3, 5'd0, 32'd4), 1'b1);
      cycle(op(ALU_AND, 5'd12, 5'd0, 32'hF0F0, 5'd0, 32'h0FF0), 1'b1);
      cycle(bub, 1'b1);

      s = op(ALU_MUL, 5'd13, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd3);
      repeat (c_mul_cycles) cycle(s, 1'b1);
      s = op(ALU_MUL, 5'd14, 5'd13, 32'd0, 5'd0, 32'd5);
      repeat (c_mul_cycles) cycle(s, 1'b1);

      s = op(ALU_MUL, 5'd15, 5'd0, 32'd7, 5'd0, 32'd9);
      cycle(s, 1'b1);
      cycle(s, 1'b1);
      cycle(s, 1'b0);
      cycle(bub, 1'b1);
      cycle(bub, 1'b1);

      cycle(op(ALU_ADD, 5'd5, 5'd0, 32'hAB, 5'd0, 32'd0), 1'b1);
      s = op(ALU_ADD, 5'd0, 5'd6, 32'h40, 5'd5, 32'd0);
      s.mem = 2'b01; s.wb = 1'b0; s.simm = 32'hFFFF_FFFC;
      cycle(s, 1'b1);

      for (int i = 0; i < 60; i++) begin
         logic [2:0] pick;
         pick = 3'($urandom_range(0, 5));
         case (pick)
            3'd0: s = op(ALU_ADD, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)), $urandom);
            3'd1: s = op(ALU_SUB, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)), $urandom);
            3'd2: s = op(ALU_AND, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)), $urandom);
            3'd3: s = op(ALU_OR,  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)), $urandom);
            3'd4: s = op(ALU_MUL, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)), $urandom);
            default: s = bub;
         endcase
         if (s.valid) begin
            s.alu_src = 1'($urandom_range(0, 1));
            s.mem     = 2'($urandom_range(0, 2));
            s.simm    = $urandom;
            s.wb      = 1'($urandom_range(0, 1));
            s.mwb     = 1'($urandom_range(0, 1));
            s.mrd     = 5'($urandom_range(0, 3));
            s.mdata   = $urandom;
         end
         if (s.valid && s.ctrl == ALU_MUL) repeat (c_mul_cycles) cycle(s, 1'b1);
         else cycle(s, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
